mem_req_ctrl: RTL and testbench

Data-side memory request initiator placed between the execute stage and the data SRAM-like bus: the write/request end of the interface whose read-data end is consumed by the MEM stage. Converts a single load/store from EX into a handshaked bus transaction, packs store data into byte lanes with a write strobe, checks alignment, and holds the returned raw 32-bit word until the pipeline accepts it. One transaction is outstanding at a time, and the block raises a stall request to the pipeline controller while busy.

---
 rtl/mem_req_pkg.sv | 28 ++
 rtl/mem_req_ctrl_if.sv | 43 ++++
 rtl/store_lane_pack.sv | 34 +++
 rtl/mem_req_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_req_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_pkg.sv
// rtl/mem_req_pkg.sv - shared types, size codes and helpers for the data-side request controller
package mem_req_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_HOLD,
    ST_CANCEL
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  // The reserved size code behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == SZ_RSVD) ? SZ_WORD : sz;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    logic [1:0] s;
    s = norm_size(sz);
    return ((s == SZ_HALF) && lo[0]) || ((s == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_req_ctrl_if.sv
// rtl/mem_req_ctrl_if.sv - EX request, pipeline handshake and data bus signals of mem_req_ctrl
interface mem_req_ctrl_if;

  logic        flush;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        pipe_ready;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        stall_req;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        except_adel;
  logic        except_ades;
  logic [31:0] bad_vaddr;

  modport master (
    input  flush, req_valid, req_we, req_size, req_addr, req_wdata, pipe_ready,
    input  data_addr_ok, data_data_ok, data_rdata,
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output stall_req, rdata_valid, rdata, except_adel, except_ades, bad_vaddr
  );

  modport slave (
    output flush, req_valid, req_we, req_size, req_addr, req_wdata, pipe_ready,
    output data_addr_ok, data_data_ok, data_rdata,
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  stall_req, rdata_valid, rdata, except_adel, except_ades, bad_vaddr
  );

endinterface

// File: rtl/store_lane_pack.sv
// rtl/store_lane_pack.sv - maps size, low address bits and right-aligned data onto byte lanes
module store_lane_pack
  import mem_req_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = 32'h0;
    if (we_i) begin
      unique case (norm_size(size_i))
        SZ_BYTE: begin
          wstrb_o = 4'b0001 << addr_lo_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        SZ_HALF: begin
          wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: begin
          wstrb_o = 4'b1111;
          wdata_o = wdata_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - single-outstanding load/store bus initiator with stall and rdata hold
// Optional alignment check: MEM_REQ_ADDR_CHECK_EN
module mem_req_ctrl
  import mem_req_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mem_req_ctrl_if.master mif
);

  state_e      state_q;
  logic        data_req_q;
  logic        data_wr_q;
  logic [1:0]  data_size_q;
  logic [31:0] data_addr_q;
  logic [3:0]  data_wstrb_q;
  logic [31:0] data_wdata_q;
  logic        rdata_valid_q;
  logic [31:0] rdata_q;
  logic        except_adel_q;
  logic        except_ades_q;
  logic [31:0] bad_vaddr_q;

  logic        addr_err;
  logic        idle_accept;
  logic [3:0]  pack_wstrb;
  logic [31:0] pack_wdata;

`ifdef MEM_REQ_ADDR_CHECK_EN
  assign addr_err = misaligned(mif.req_size, mif.req_addr[1:0]);
`else
  assign addr_err = 1'b0;
`endif

  assign idle_accept = (state_q == ST_IDLE) && mif.req_valid && !addr_err;

  store_lane_pack u_pack (
    .size_i    (mif.req_size),
    .addr_lo_i (mif.req_addr[1:0]),
    .we_i      (mif.req_we),
    .wdata_i   (mif.req_wdata),
    .wstrb_o   (pack_wstrb),
    .wdata_o   (pack_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      data_req_q    <= 1'b0;
      data_wr_q     <= 1'b0;
      data_size_q   <= 2'd0;
      data_addr_q   <= 32'h0;
      data_wstrb_q  <= 4'b0000;
      data_wdata_q  <= 32'h0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= 32'h0;
      except_adel_q <= 1'b0;
      except_ades_q <= 1'b0;
      bad_vaddr_q   <= 32'h0;
    end else begin
      except_adel_q <= 1'b0;
      except_ades_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (mif.req_valid && addr_err) begin
            except_adel_q <= !mif.req_we;
            except_ades_q <= mif.req_we;
            bad_vaddr_q   <= mif.req_addr;
          end else if (mif.req_valid) begin
            state_q      <= ST_ADDR;
            data_req_q   <= 1'b1;
            data_wr_q    <= mif.req_we;
            data_size_q  <= mif.req_size;
            data_addr_q  <= mif.req_addr;
            data_wstrb_q <= pack_wstrb;
            data_wdata_q <= pack_wdata;
          end
        end
        ST_ADDR: begin
          // An accepted request still owes a response, so a flush must drain it.
          if (mif.flush) begin
            data_req_q <= 1'b0;
            state_q    <= mif.data_addr_ok ? ST_CANCEL : ST_IDLE;
          end else if (mif.data_addr_ok) begin
            data_req_q <= 1'b0;
            state_q    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mif.data_data_ok) begin
            if (!mif.flush && !data_wr_q) begin
              rdata_q       <= mif.data_rdata;
              rdata_valid_q <= 1'b1;
              state_q       <= ST_HOLD;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (mif.flush) begin
            state_q <= ST_CANCEL;
          end
        end
        ST_HOLD: begin
          if (mif.pipe_ready || mif.flush) begin
            rdata_valid_q <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end
        ST_CANCEL: begin
          if (mif.data_data_ok) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The IDLE term is combinational so EX freezes in the cycle the op arrives.
  assign mif.stall_req   = (state_q != ST_IDLE) || idle_accept;
  assign mif.data_req    = data_req_q;
  assign mif.data_wr     = data_wr_q;
  assign mif.data_size   = data_size_q;
  assign mif.data_addr   = data_addr_q;
  assign mif.data_wstrb  = data_wstrb_q;
  assign mif.data_wdata  = data_wdata_q;
  assign mif.rdata_valid = rdata_valid_q;
  assign mif.rdata       = rdata_q;
  assign mif.except_adel = except_adel_q;
  assign mif.except_ades = except_ades_q;
  assign mif.bad_vaddr   = bad_vaddr_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - directed self-checking bench for mem_req_ctrl
module tb_mem_req_ctrl;
  import mem_req_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  mem_req_ctrl_if bus ();

  mem_req_ctrl dut (
    .clk (clk),
    .rst (rst),
    .mif (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush        = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.pipe_ready   = 1'b0;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'h0;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    #1;
    n_cmp++; if (bus.data_req !== 1'b0) begin n_fail++; $display("FAIL reset_data_req got %b want 0", bus.data_req); end
    n_cmp++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.stall_req); end
    n_cmp++; if ({bus.data_wr, bus.data_size, bus.data_wstrb} !== 7'h0) begin n_fail++; $display("FAIL reset_ctl got %h want 0", {bus.data_wr, bus.data_size, bus.data_wstrb}); end
    n_cmp++; if ({bus.data_addr, bus.data_wdata, bus.rdata, bus.bad_vaddr} !== 128'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", {bus.data_addr, bus.data_wdata, bus.rdata, bus.bad_vaddr}); end
    n_cmp++; if ({bus.rdata_valid, bus.except_adel, bus.except_ades} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {bus.rdata_valid, bus.except_adel, bus.except_ades}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store_word();
    issue(1'b1, SZ_WORD, 32'h100, 32'h11223344);
    #1;
    n_cmp++; if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL sw_stall_T got %b want 1", bus.stall_req); end
    n_cmp++; if (bus.data_req !== 1'b0) begin n_fail++; $display("FAIL sw_req_T got %b want 0", bus.data_req); end
    tick();
    clear_inputs();
    bus.data_addr_ok = 1'b1;
    #1;
    n_cmp++; if (bus.data_req !== 1'b1) begin n_fail++; $display("FAIL sw_req_T1 got %b want 1", bus.data_req); end
    n_cmp++; if (bus.data_wr !== 1'b1) begin n_fail++; $display("FAIL sw_wr got %b want 1", bus.data_wr); end
    n_cmp++; if (bus.data_wstrb !== 4'b1111) begin n_fail++; $display("FAIL sw_wstrb got %b want 1111", bus.data_wstrb); end
    n_cmp++; if (bus.data_wdata !== 32'h11223344) begin n_fail++; $display("FAIL sw_wdata got %h want 11223344", bus.data_wdata); end
    n_cmp++; if (bus.data_addr !== 32'h100) begin n_fail++; $display("FAIL sw_addr got %h want 100", bus.data_addr); end
    n_cmp++; if (bus.data_size !== SZ_WORD) begin n_fail++; $display("FAIL sw_size got %0d want 2", bus.data_size); end
    tick();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    #1;
    n_cmp++; if (bus.data_req !== 1'b0) begin n_fail++; $display("FAIL sw_req_T2 got %b want 0", bus.data_req); end
    n_cmp++; if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL sw_stall_T2 got %b want 1", bus.stall_req); end
    tick();
    bus.data_data_ok = 1'b0;
    #1;
    n_cmp++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL sw_stall_T3 got %b want 0", bus.stall_req); end
  endtask

  task automatic test_store_byte_wait();
    issue(1'b1, SZ_BYTE, 32'h103, 32'h000000AB);
    tick();
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      bus.data_addr_ok = (c == 3);
      bus.req_wdata = 32'hFFFF_0000 + c;
      #1;
      n_cmp++; if (bus.data_req !== 1'b1) begin n_fail++; $display("FAIL sb_req c%0d got %b want 1", c, bus.data_req); end
      n_cmp++; if (bus.data_addr !== 32'h103) begin n_fail++; $display("FAIL sb_addr c%0d got %h want 103", c, bus.data_addr); end
      n_cmp++; if (bus.data_wstrb !== 4'b1000) begin n_fail++; $display("FAIL sb_wstrb c%0d got %b want 1000", c, bus.data_wstrb); end
      n_cmp++; if (bus.data_wdata !== 32'hABABABAB) begin n_fail++; $display("FAIL sb_wdata c%0d got %h want ABABABAB", c, bus.data_wdata); end
      tick();
    end
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    #1;
    n_cmp++; if (bus.data_req !== 1'b0) begin n_fail++; $display("FAIL sb_req_drop got %b want 0", bus.data_req); end
    tick();
    bus.data_data_ok = 1'b0;
    #1;
    n_cmp++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL sb_idle_stall got %b want 0", bus.stall_req); end
  endtask

  task automatic test_store_half_rsvd();
    issue(1'b1, SZ_HALF, 32'h102, 32'hFFFF1234);
    tick();
    clear_inputs();
    bus.data_addr_ok = 1'b1;
    #1;
    n_cmp++; if (bus.data_wstrb !== 4'b1100) begin n_fail++; $display("FAIL sh_wstrb got %b want 1100", bus.data_wstrb); end
    n_cmp++; if (bus.data_wdata !== 32'h12341234) begin n_fail++; $display("FAIL sh_wdata got %h want 12341234", bus.data_wdata); end
    tick();
    clear_inputs();
    bus.data_data_ok = 1'b1;
    tick();
    clear_inputs();
    issue(1'b1, SZ_RSVD, 32'h104, 32'hCAFEF00D);
    tick();
    clear_inputs();
    bus.data_addr_ok = 1'b1;
    #1;
    n_cmp++; if (bus.data_wstrb !== 4'b1111) begin n_fail++; $display("FAIL rsvd_wstrb got %b want 1111", bus.data_wstrb); end
    n_cmp++; if (bus.data_size !== 2'd3) begin n_fail++; $display("FAIL rsvd_size got %0d want 3", bus.data_size); end
    tick();
    clear_inputs();
    bus.data_data_ok = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_load_hold();
    issue(1'b0, SZ_WORD, 32'h200, 32'h0);
    tick();
    clear_inputs();
    bus.data_addr_ok = 1'b1;
    #1;
    n_cmp++; if (bus.data_wstrb !== 4'b0000) begin n_fail++; $display("FAIL lw_wstrb got %b want 0000", bus.data_wstrb); end
    n_cmp++; if (bus.data_wr !== 1'b0) begin n_fail++; $display("FAIL lw_wr got %b want 0", bus.data_wr); end
    tick();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'hDEADBEEF;
    tick();
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'h0;
    for (int c = 0; c < 3; c++) begin
      bus.pipe_ready = (c == 2);
      #1;
      n_cmp++; if (bus.rdata_valid !== 1'b1) begin n_fail++; $display("FAIL lw_valid c%0d got %b want 1", c, bus.rdata_valid); end
      n_cmp++; if (bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata c%0d got %h want DEADBEEF", c, bus.rdata); end
      n_cmp++; if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL lw_stall c%0d got %b want 1", c, bus.stall_req); end
      tick();
    end
    bus.pipe_ready = 1'b0;
    #1;
    n_cmp++; if (bus.rdata_valid !== 1'b0) begin n_fail++; $display("FAIL lw_valid_clr got %b want 0", bus.rdata_valid); end
    n_cmp++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL lw_stall_clr got %b want 0", bus.stall_req); end
  endtask

  task automatic test_flush_data();
    logic seen_valid;
    seen_valid = 1'b0;
    issue(1'b0, SZ_WORD, 32'h400, 32'h0);
    tick();
    clear_inputs();
    bus.data_addr_ok = 1'b1;
    tick();
    clear_inputs();
    bus.flush = 1'b1;
    tick();
    clear_inputs();
    #1;
    seen_valid |= bus.rdata_valid;
    n_cmp++; if (dut.state_q !== ST_CANCEL) begin n_fail++; $display("FAIL fl_cancel_state got %0d want %0d", dut.state_q, ST_CANCEL); end
    n_cmp++; if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL fl_cancel_stall got %b want 1", bus.stall_req); end
    tick();
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h55555555;
    bus.req_valid    = 1'b1;
    #1;
    seen_valid |= bus.rdata_valid;
    n_cmp++; if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL fl_cancel_stall2 got %b want 1", bus.stall_req); end
    tick();
    clear_inputs();
    issue(1'b0, SZ_WORD, 32'h500, 32'h0);
    #1;
    seen_valid |= bus.rdata_valid;
    n_cmp++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL fl_idle_state got %0d want %0d", dut.state_q, ST_IDLE); end
    n_cmp++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL fl_no_valid got %b want 0", seen_valid); end
    tick();
    clear_inputs();
    bus.data_addr_ok = 1'b1;
    #1;
    n_cmp++; if ({bus.data_req, bus.data_addr} !== {1'b1, 32'h500}) begin n_fail++; $display("FAIL fl_new_req got %h want 1_00000500", {bus.data_req, bus.data_addr}); end
    tick();
    clear_inputs();
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h12345678;
    tick();
    clear_inputs();
    bus.pipe_ready = 1'b1;
    #1;
    n_cmp++; if ({bus.rdata_valid, bus.rdata} !== {1'b1, 32'h12345678}) begin n_fail++; $display("FAIL fl_new_rdata got %h want 1_12345678", {bus.rdata_valid, bus.rdata}); end
    tick();
    clear_inputs();
  endtask

  task automatic test_flush_addr();
    issue(1'b1, SZ_WORD, 32'h600, 32'h77);
    tick();
    clear_inputs();
    bus.flush = 1'b1;
    #1;
    n_cmp++; if (bus.data_req !== 1'b1) begin n_fail++; $display("FAIL fa_req got %b want 1", bus.data_req); end
    tick();
    clear_inputs();
    #1;
    n_cmp++; if ({bus.data_req, bus.stall_req} !== 2'b00) begin n_fail++; $display("FAIL fa_withdraw got %b want 00", {bus.data_req, bus.stall_req}); end
  endtask

  task automatic test_misaligned();
`ifdef MEM_REQ_ADDR_CHECK_EN
    issue(1'b0, SZ_HALF, 32'h301, 32'h0);
    #1;
    n_cmp++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL lh_stall got %b want 0", bus.stall_req); end
    tick();
    clear_inputs();
    #1;
    n_cmp++; if ({bus.except_adel, bus.except_ades, bus.data_req} !== 3'b100) begin n_fail++; $display("FAIL lh_exc got %b want 100", {bus.except_adel, bus.except_ades, bus.data_req}); end
    n_cmp++; if (bus.bad_vaddr !== 32'h301) begin n_fail++; $display("FAIL lh_vaddr got %h want 301", bus.bad_vaddr); end
    tick();
    n_cmp++; if ({bus.except_adel, bus.bad_vaddr} !== {1'b0, 32'h301}) begin n_fail++; $display("FAIL lh_pulse got %h want 0_00000301", {bus.except_adel, bus.bad_vaddr}); end
    issue(1'b1, SZ_WORD, 32'h302, 32'h1);
    tick();
    clear_inputs();
    #1;
    n_cmp++; if ({bus.except_adel, bus.except_ades, bus.data_req} !== 3'b010) begin n_fail++; $display("FAIL sw_mis_exc got %b want 010", {bus.except_adel, bus.except_ades, bus.data_req}); end
    n_cmp++; if (bus.bad_vaddr !== 32'h302) begin n_fail++; $display("FAIL sw_mis_vaddr got %h want 302", bus.bad_vaddr); end
    tick();
    n_cmp++; if ({bus.except_ades, bus.stall_req} !== 2'b00) begin n_fail++; $display("FAIL sw_mis_pulse got %b want 00", {bus.except_ades, bus.stall_req}); end
`else
    issue(1'b0, SZ_HALF, 32'h301, 32'h0);
    #1;
    n_cmp++; if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL lh_nochk_stall got %b want 1", bus.stall_req); end
    tick();
    clear_inputs();
    bus.data_addr_ok = 1'b1;
    #1;
    n_cmp++; if ({bus.data_req, bus.data_addr} !== {1'b1, 32'h301}) begin n_fail++; $display("FAIL lh_nochk_req got %h want 1_00000301", {bus.data_req, bus.data_addr}); end
    n_cmp++; if ({bus.except_adel, bus.except_ades, bus.bad_vaddr} !== 34'h0) begin n_fail++; $display("FAIL lh_nochk_exc got %h want 0", {bus.except_adel, bus.except_ades, bus.bad_vaddr}); end
    tick();
    clear_inputs();
    bus.data_data_ok = 1'b1;
    tick();
    clear_inputs();
    bus.pipe_ready = 1'b1;
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL lh_nochk_done got %b want 0", bus.stall_req); end
`endif
  endtask

  task automatic test_reset_mid_addr();
    issue(1'b1, SZ_BYTE, 32'h701, 32'h5A);
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL rst_mid_state got %0d want %0d", dut.state_q, ST_IDLE); end
    n_cmp++; if ({bus.data_req, bus.data_wr, bus.stall_req, bus.data_size, bus.data_wstrb} !== 9'h0) begin n_fail++; $display("FAIL rst_mid_ctl got %h want 0", {bus.data_req, bus.data_wr, bus.stall_req, bus.data_size, bus.data_wstrb}); end
    n_cmp++; if ({bus.data_addr, bus.data_wdata} !== 64'h0) begin n_fail++; $display("FAIL rst_mid_data got %h want 0", {bus.data_addr, bus.data_wdata}); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_store_word();
    test_store_byte_wait();
    test_store_half_rsvd();
    test_load_hold();
    test_flush_data();
    test_flush_addr();
    test_misaligned();
    test_reset_mid_addr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
